// File: rtl/irrigation_controller_pkg.sv
// Shared definitions for the irrigation mode controller: state encodings, mode codes
// consumed by the 7-segment decoder, moisture levels and counter-width helper.
package irrigation_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPRINKLER = 3'd1,
    ST_DRIP      = 3'd2,
    ST_BLOCKED   = 3'd3,
    ST_COOLDOWN  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_IDLE      = 2'b00;
  localparam logic [1:0] MODE_SPRINKLER = 2'b01;
  localparam logic [1:0] MODE_DRIP      = 2'b10;
  localparam logic [1:0] MODE_BLOCKED   = 2'b11;

  localparam logic [1:0] MOIST_VERY_DRY = 2'b00;
  localparam logic [1:0] MOIST_DRY      = 2'b01;
  localparam logic [1:0] MOIST_OK       = 2'b10;
  localparam logic [1:0] MOIST_WET      = 2'b11;

  // A one-value counter still needs a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      ST_SPRINKLER: return MODE_SPRINKLER;
      ST_DRIP:      return MODE_DRIP;
      ST_BLOCKED:   return MODE_BLOCKED;
      default:      return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/irrigation_controller_if.sv
// Sensor inputs and mode/valve outputs of the irrigation controller.
interface irrigation_controller_if;
  logic       sys_en;
  logic [1:0] moisture;
  logic       temp_high;
  logic       tank_low;
  logic       bit0;
  logic       bit1;
  logic       sprinkler_valve;
  logic       drip_valve;
  logic       busy;

  modport master (
    output sys_en, moisture, temp_high, tank_low,
    input  bit0, bit1, sprinkler_valve, drip_valve, busy
  );

  modport slave (
    input  sys_en, moisture, temp_high, tank_low,
    output bit0, bit1, sprinkler_valve, drip_valve, busy
  );
endinterface

// File: rtl/irrigation_controller_sync_2ff.sv
// Two-flop synchronizer, parameterised width, asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/irrigation_controller.sv
// Irrigation mode controller: picks sprinkler/drip/blocked mode from synchronized sensors.
// Optional post-session COOLDOWN state is built when IRRIG_COOLDOWN_EN is defined.
module irrigation_controller
  import irrigation_controller_pkg::*;
#(
  parameter int WATER_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  irrigation_controller_if.slave   io
);
  localparam int WW = cnt_width(WATER_CYCLES);
  localparam int LW = cnt_width(LOCKOUT_CYCLES);
  localparam logic [WW-1:0] WATER_LAST = WW'(WATER_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
`ifdef IRRIG_COOLDOWN_EN
  localparam int CW = cnt_width(COOLDOWN_CYCLES);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_CYCLES - 1);
  localparam state_t SESSION_END = ST_COOLDOWN;
`else
  localparam state_t SESSION_END = ST_IDLE;
`endif

  logic [3:0] sens_sync;
  logic [1:0] moist_s;
  logic       temp_s;
  logic       tank_s;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({io.tank_low, io.temp_high, io.moisture}),
    .q     (sens_sync)
  );

  assign moist_s = sens_sync[1:0];
  assign temp_s  = sens_sync[2];
  assign tank_s  = sens_sync[3];

  state_t          state_reg, state_next;
  logic [WW-1:0]   water_reg, water_next;
  logic [LW-1:0]   lock_reg,  lock_next;
`ifdef IRRIG_COOLDOWN_EN
  logic [CW-1:0]   cool_reg,  cool_next;
`endif
  logic [1:0]      mode_reg;
  logic            spr_reg, drip_reg, busy_reg;

  always_comb begin
    state_next = state_reg;
    water_next = water_reg;
    lock_next  = lock_reg;
`ifdef IRRIG_COOLDOWN_EN
    cool_next  = cool_reg;
`endif
    // A low tank preempts everything except an already running lockout.
    if (tank_s && state_reg != ST_BLOCKED) begin
      state_next = ST_BLOCKED;
      lock_next  = '0;
    end else begin
      case (state_reg)
        ST_BLOCKED: begin
          if (lock_reg < LOCK_LAST)
            lock_next = lock_reg + 1'b1;
          else if (!tank_s)
            state_next = ST_IDLE;
        end
        ST_IDLE: begin
          water_next = '0;
          if (io.sys_en) begin
            if (moist_s == MOIST_VERY_DRY)
              state_next = temp_s ? ST_DRIP : ST_SPRINKLER;
            else if (moist_s == MOIST_DRY)
              state_next = ST_DRIP;
          end
        end
        ST_SPRINKLER, ST_DRIP: begin
          if (!io.sys_en || moist_s[1] || water_reg == WATER_LAST) begin
            state_next = SESSION_END;
`ifdef IRRIG_COOLDOWN_EN
            cool_next  = '0;
`endif
          end else begin
            water_next = water_reg + 1'b1;
          end
        end
`ifdef IRRIG_COOLDOWN_EN
        ST_COOLDOWN: begin
          if (cool_reg == COOL_LAST)
            state_next = ST_IDLE;
          else
            cool_next = cool_reg + 1'b1;
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      water_reg <= '0;
      lock_reg  <= '0;
`ifdef IRRIG_COOLDOWN_EN
      cool_reg  <= '0;
`endif
      mode_reg  <= MODE_IDLE;
      spr_reg   <= 1'b0;
      drip_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      water_reg <= water_next;
      lock_reg  <= lock_next;
`ifdef IRRIG_COOLDOWN_EN
      cool_reg  <= cool_next;
`endif
      mode_reg  <= mode_of(state_next);
      spr_reg   <= (state_next == ST_SPRINKLER);
      drip_reg  <= (state_next == ST_DRIP);
      busy_reg  <= (state_next == ST_SPRINKLER) || (state_next == ST_DRIP);
    end
  end

  assign io.bit0            = mode_reg[0];
  assign io.bit1            = mode_reg[1];
  assign io.sprinkler_valve = spr_reg;
  assign io.drip_valve      = drip_reg;
  assign io.busy            = busy_reg;
endmodule
